// File: rtl/fifo_wr_ingress.sv
// -----------------------------------------------------------------------------
// fifo_wr_ingress
//
// Write-domain front end of the async FIFO. It takes words from the write-side
// source over a valid/ready handshake and keeps them in a 2-entry skid buffer.
// It drives winc/wdata into the write-pointer stage and the dual-port memory.
// It synchronises the read-domain Gray pointer into wclk, and it reports a
// conservative fill level and an almost-full flag.
//
// FIFO depth is 2^(P_WIDTH-1). The pointers carry one extra wrap bit.
//
// Optional build macro: FIFO_WR_SYNC3_EN
//   defined   -> 3-flop rptr synchroniser (wq2_rptr lags rptr by 3 wclk edges)
//   undefined -> 2-flop rptr synchroniser (default)
//
// Ports:
//   wclk          in   write-domain clock
//   wrst          in   asynchronous active-low reset
//   s_valid       in   source word valid
//   s_data        in   source word
//   s_ready       out  block can accept a word this cycle (registered)
//   winc          out  write request / memory write enable
//   wdata         out  word to memory, valid when winc=1
//   wfull         in   registered full flag from the write-pointer stage
//   wptr          in   Gray write pointer from the write-pointer stage
//   rptr          in   Gray read pointer from the read domain (asynchronous)
//   wq2_rptr      out  rptr synchronised into wclk
//   wlevel        out  fill level 0..DEPTH (registered)
//   walmost_full  out  wlevel >= AFULL_THRESH (registered)
// -----------------------------------------------------------------------------
module fifo_wr_ingress #(
    parameter int P_WIDTH      = 4,
    parameter int D_WIDTH      = 8,
    parameter int AFULL_THRESH = 6
) (
    input  logic               wclk,
    input  logic               wrst,
    input  logic               s_valid,
    input  logic [D_WIDTH-1:0] s_data,
    output logic               s_ready,
    output logic               winc,
    output logic [D_WIDTH-1:0] wdata,
    input  logic               wfull,
    input  logic [P_WIDTH-1:0] wptr,
    input  logic [P_WIDTH-1:0] rptr,
    output logic [P_WIDTH-1:0] wq2_rptr,
    output logic [P_WIDTH-1:0] wlevel,
    output logic               walmost_full
);

    localparam logic [P_WIDTH-1:0] LP_AFULL = P_WIDTH'(AFULL_THRESH);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [P_WIDTH-1:0] gray2bin(input logic [P_WIDTH-1:0] g);
        logic [P_WIDTH-1:0] b;
        b[P_WIDTH-1] = g[P_WIDTH-1];
        for (int i = P_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // ------------------------------------------------------------------------
    // Read-pointer synchroniser (plain flop chain, no logic between stages)
    // ------------------------------------------------------------------------
`ifdef FIFO_WR_SYNC3_EN
    logic [P_WIDTH-1:0] r_sync1;
    logic [P_WIDTH-1:0] r_sync2;
    logic [P_WIDTH-1:0] r_sync3;

    // Three-stage metastability chain for the asynchronous read pointer
    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            r_sync1 <= {P_WIDTH{1'b0}};
            r_sync2 <= {P_WIDTH{1'b0}};
            r_sync3 <= {P_WIDTH{1'b0}};
        end else begin
            r_sync1 <= rptr;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign wq2_rptr = r_sync3;
`else
    logic [P_WIDTH-1:0] r_sync1;
    logic [P_WIDTH-1:0] r_sync2;

    // Two-stage metastability chain for the asynchronous read pointer
    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            r_sync1 <= {P_WIDTH{1'b0}};
            r_sync2 <= {P_WIDTH{1'b0}};
        end else begin
            r_sync1 <= rptr;
            r_sync2 <= r_sync1;
        end
    end

    assign wq2_rptr = r_sync2;
`endif

    // ------------------------------------------------------------------------
    // Skid buffer
    // ------------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;
    logic [D_WIDTH-1:0] r_out;
    logic [D_WIDTH-1:0] r_skid;
    logic [D_WIDTH-1:0] w_out_nxt;
    logic [D_WIDTH-1:0] w_skid_nxt;
    logic               r_s_ready;
    logic               w_accept;
    logic               w_winc;

    assign w_accept = s_valid & r_s_ready;
    // The head word goes out whenever one is held and the FIFO has room.
    assign w_winc   = (r_state != ST_EMPTY) & ~wfull;

    // Next-state and data-path selection for the skid buffer
    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_skid_nxt  = r_skid;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_out_nxt   = s_data;
                    w_state_nxt = ST_ONE;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (w_accept && w_winc) begin
                    w_out_nxt   = s_data;
                    w_state_nxt = ST_ONE;
                end else if (w_accept) begin
                    // Head is stalled: park the new word behind it.
                    w_skid_nxt  = s_data;
                    w_state_nxt = ST_TWO;
                end else if (w_winc) begin
                    w_state_nxt = ST_EMPTY;
                end else begin
                    w_state_nxt = ST_ONE;
                end
            end
            ST_TWO: begin
                // s_ready is low here, so only draining can happen.
                if (w_winc) begin
                    w_out_nxt   = r_skid;
                    w_state_nxt = ST_ONE;
                end else begin
                    w_state_nxt = ST_TWO;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Skid-buffer state, data registers and registered ready
    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            r_state   <= ST_EMPTY;
            r_out     <= {D_WIDTH{1'b0}};
            r_skid    <= {D_WIDTH{1'b0}};
            r_s_ready <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_out     <= w_out_nxt;
            r_skid    <= w_skid_nxt;
            // Ready is computed from the next state, so it has no path from wfull or s_valid.
            r_s_ready <= (w_state_nxt != ST_TWO);
        end
    end

    assign s_ready = r_s_ready;
    assign winc    = w_winc;
    assign wdata   = r_out;

    // ------------------------------------------------------------------------
    // Fill level (conservative: a stale read pointer only overestimates)
    // ------------------------------------------------------------------------
    logic [P_WIDTH-1:0] w_wbin;
    logic [P_WIDTH-1:0] w_rbin;
    logic [P_WIDTH-1:0] w_level_nxt;
    logic [P_WIDTH-1:0] r_wlevel;
    logic               r_afull;

    assign w_wbin      = gray2bin(wptr);
    assign w_rbin      = gray2bin(wq2_rptr);
    // Modulo-2^P_WIDTH subtraction absorbs pointer wrap.
    assign w_level_nxt = w_wbin - w_rbin;

    // Registered level and almost-full flag, updated together
    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            r_wlevel <= {P_WIDTH{1'b0}};
            r_afull  <= 1'b0;
        end else begin
            r_wlevel <= w_level_nxt;
            r_afull  <= (w_level_nxt >= LP_AFULL);
        end
    end

    assign wlevel       = r_wlevel;
    assign walmost_full = r_afull;

endmodule

// File: tb/tb_fifo_wr_ingress.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_ingress
//
// Self-checking bench for fifo_wr_ingress. A behavioural model (a word queue,
// a list of sampled read pointers, and arithmetic on decoded pointers) predicts
// every output on every cycle. Directed steps cover reset, a single word,
// backpressure, sync latency, level/wrap and a mid-operation reset. A random
// phase follows them.
// -----------------------------------------------------------------------------
module tb_fifo_wr_ingress;

`ifdef FIFO_WR_SYNC3_EN
    localparam int SYNC = 3;
`else
    localparam int SYNC = 2;
`endif
    localparam int THRESH = 6;

    logic       wclk;
    logic       wrst;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       winc;
    logic [7:0] wdata;
    logic       wfull;
    logic [3:0] wptr;
    logic [3:0] rptr;
    logic [3:0] wq2_rptr;
    logic [3:0] wlevel;
    logic       walmost_full;

    fifo_wr_ingress #(.P_WIDTH(4), .D_WIDTH(8), .AFULL_THRESH(THRESH)) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .winc         (winc),
        .wdata        (wdata),
        .wfull        (wfull),
        .wptr         (wptr),
        .rptr         (rptr),
        .wq2_rptr     (wq2_rptr),
        .wlevel       (wlevel),
        .walmost_full (walmost_full)
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [7:0] q[$];
    logic [3:0] rq[$];
    logic       m_ready;
    logic       m_winc;
    logic [3:0] m_wq2;
    logic [3:0] m_level;
    logic       m_af;
    logic [7:0] wr_log[$];

    // Decode Gray by searching for the binary value whose Gray code matches.
    function automatic int g2b(input logic [3:0] g);
        for (int n = 0; n < 16; n++) begin
            if (4'(n ^ (n >> 1)) == g) return n;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        q.delete();
        rq.delete();
        for (int i = 0; i < SYNC; i++) rq.push_back(4'd0);
        m_ready = 1'b0;
        m_wq2   = 4'd0;
        m_level = 4'd0;
        m_af    = 1'b0;
    endtask

    // One clock cycle: check all outputs, then advance the model at the edge.
    task automatic step();
        logic acc;
        #1;
        if (!wrst) mreset();
        m_winc = (q.size() > 0) && !wfull;
        chk("s_ready", 32'(s_ready), 32'(m_ready));
        chk("winc", 32'(winc), 32'(m_winc));
        if (q.size() > 0) chk("wdata", 32'(wdata), 32'(q[0]));
        else if (!wrst) chk("wdata_rst", 32'(wdata), 32'd0);
        chk("wq2_rptr", 32'(wq2_rptr), 32'(m_wq2));
        chk("wlevel", 32'(wlevel), 32'(m_level));
        chk("walmost_full", 32'(walmost_full), 32'(m_af));
        if (winc === 1'b1) wr_log.push_back(wdata);
        @(posedge wclk);
        if (!wrst) begin
            mreset();
        end else begin
            acc = s_valid && m_ready;
            if (m_winc) void'(q.pop_front());
            if (acc) q.push_back(s_data);
            m_ready = (q.size() < 2);
            m_level = 4'((g2b(wptr) - g2b(m_wq2)) & 15);
            m_af    = (int'(m_level) >= THRESH);
            rq.push_back(rptr);
            void'(rq.pop_front());
            m_wq2 = rq[0];
        end
        @(negedge wclk);
    endtask

    initial begin
        logic [7:0] vals[4];
        int idx;
        mreset();
        wrst = 1'b1; s_valid = 1'b1; s_data = 8'h00; wfull = 1'b0;
        wptr = 4'd0; rptr = 4'b0101;
        #2 wrst = 1'b0;
        @(negedge wclk);

        // 1. reset with active inputs
        for (int i = 0; i < 3; i++) step();
        #1;
        chk("t1_sready", 32'(s_ready), 32'd0);
        chk("t1_wlevel", 32'(wlevel), 32'd0);
        chk("t1_wq2", 32'(wq2_rptr), 32'd0);
        wrst = 1'b1; s_valid = 1'b0; rptr = 4'd0;
        step();
        #1;
        chk("t1_sready_up", 32'(s_ready), 32'd1);
        chk("t1_no_winc", 32'(winc), 32'd0);
        for (int i = 0; i < 3; i++) step();

        // 2. single word
        s_valid = 1'b1; s_data = 8'hA5; wfull = 1'b0;
        step();
        s_valid = 1'b0;
        #1;
        chk("t2_winc", 32'(winc), 32'd1);
        chk("t2_wdata", 32'(wdata), 32'hA5);
        step();
        #1;
        chk("t2_winc_once", 32'(winc), 32'd0);
        step();

        // 3. backpressure
        vals[0] = 8'h01; vals[1] = 8'h02; vals[2] = 8'h03; vals[3] = 8'h04;
        idx = 0;
        wr_log.delete();
        for (int c = 0; c < 10; c++) begin
            wfull   = (c >= 1 && c <= 3);
            s_valid = (idx < 4);
            s_data  = vals[idx % 4];
            #1;
            if (c == 2) begin
                chk("t3_sready_two", 32'(s_ready), 32'd0);
                chk("t3_head", 32'(wdata), 32'h01);
            end
            if (s_valid && s_ready) idx++;
            step();
        end
        s_valid = 1'b0;
        chk("t3_count", 32'(wr_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wr_log.size()) chk("t3_order", 32'(wr_log[i]), 32'(vals[i]));
        end

        // 4. sync latency
        wptr = 4'd0; rptr = 4'd0;
        for (int i = 0; i < 4; i++) step();
        rptr = 4'b0001;
        for (int k = 1; k <= SYNC; k++) begin
            step();
            #1;
            chk("t4_wq2", 32'(wq2_rptr), (k == SYNC) ? 32'd1 : 32'd0);
        end

        // 5. level and wrap
        wptr = 4'b0101; rptr = 4'b0000;
        for (int i = 0; i < SYNC + 2; i++) step();
        #1;
        chk("t5_lvl6", 32'(wlevel), 32'd6);
        chk("t5_af1", 32'(walmost_full), 32'd1);
        rptr = 4'b0011;
        for (int i = 0; i < SYNC + 2; i++) step();
        #1;
        chk("t5_lvl4", 32'(wlevel), 32'd4);
        chk("t5_af0", 32'(walmost_full), 32'd0);
        wptr = 4'b1101; rptr = 4'b0010;
        for (int i = 0; i < SYNC + 2; i++) step();
        #1;
        chk("t5_wrap6", 32'(wlevel), 32'd6);
        wptr = 4'b1100; rptr = 4'b0000;
        for (int i = 0; i < SYNC + 2; i++) step();
        #1;
        chk("t5_lvl8", 32'(wlevel), 32'd8);
        chk("t5_af8", 32'(walmost_full), 32'd1);
        step();

        // 6. reset mid-operation
        wfull = 1'b1; s_valid = 1'b1; s_data = 8'h01;
        step();
        s_data = 8'h02;
        step();
        #1;
        chk("t6_two", 32'(s_ready), 32'd0);
        s_valid = 1'b0;
        wrst = 1'b0;
        #1;
        chk("t6_winc", 32'(winc), 32'd0);
        chk("t6_wdata", 32'(wdata), 32'd0);
        chk("t6_wlevel", 32'(wlevel), 32'd0);
        step();
        wrst = 1'b1; wfull = 1'b0;
        step();
        step();
        wr_log.delete();
        s_valid = 1'b1; s_data = 8'h33;
        step();
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("t6_count", 32'(wr_log.size()), 32'd1);
        if (wr_log.size() > 0) chk("t6_word", 32'(wr_log[0]), 32'h33);

        // random phase
        for (int c = 0; c < 400; c++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = 8'($urandom);
            wfull   = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 3) == 0) wptr = 4'($urandom);
            if ($urandom_range(0, 3) == 0) rptr = 4'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
